// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe game engine.
//   cell_t    : 2-bit cell code as seen on board_cells
//   state_t   : game FSM states
//   W_*       : winner output encodings
//   WIN_LINES : the 8 winning lines as three cell indices each, in line-id order
//   mark_of   : cell code written for the player whose turn it is
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        CELL_X = 2'b01,
        CELL_O = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        ST_TURN,
        ST_PLACE,
        ST_CHECK,
        ST_WIN_X,
        ST_WIN_O,
        ST_DRAW
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_X    = 2'b01;
    localparam logic [1:0] W_O    = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Line ids 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // turn = 0 means X to move, 1 means O to move.
    function automatic cell_t mark_of(input logic turn);
        return turn ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/win_line_detector.sv
// Combinational win detector.
//   board   in  9x2  cell i at board[i] (00 empty, 01 X, 10 O)
//   player  in  2    cell code to look for
//   found   out 1    some line is completely filled with player
//   line_id out 3    lowest-numbered completed line (0 when none)
module win_line_detector
    import tictactoe_pkg::*;
(
    input  logic [8:0][1:0] board,
    input  logic [1:0]      player,
    output logic            found,
    output logic [2:0]      line_id
);

    // Scan from the highest id down so the lowest completed line wins.
    always_comb begin
        found   = 1'b0;
        line_id = 3'd0;
        for (int l = 7; l >= 0; l--) begin
            if (board[WIN_LINES[l][0]] == player &&
                board[WIN_LINES[l][1]] == player &&
                board[WIN_LINES[l][2]] == player) begin
                found   = 1'b1;
                line_id = 3'(l);
            end
        end
    end

endmodule

// File: rtl/tictactoe_game_fsm.sv
// Tic-tac-toe game-state engine: board, turn order, per-turn timeout with
// auto-move, win/draw detection.
//   Clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   position     in   4   selected square 0..8, 9..15 invalid
//   playX/playO  in   1   move request levels (asynchronous)
//   new_game     in   1   restart request level (asynchronous)
//   board_cells  out  18  cell i at [2i+1:2i]
//   turn         out  1   0 X to move, 1 O to move
//   winner       out  2   00 none, 01 X, 10 O, 11 draw
//   game_over    out  1   game finished
//   win_line     out  3   winning line id
//   seconds_left out  4   remaining seconds of the current turn
//   move_count   out  4   cells filled
//   illegal_move out  1   one-cycle pulse on a rejected request
module tictactoe_game_fsm
    import tictactoe_pkg::*;
#(
    parameter int CLK_HZ       = 25_000_000,
    parameter int TURN_SECONDS = 15
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [3:0]  position,
    input  logic        playX,
    input  logic        playO,
    input  logic        new_game,
    output logic [17:0] board_cells,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [2:0]  win_line,
    output logic [3:0]  seconds_left,
    output logic [3:0]  move_count,
    output logic        illegal_move
);

    localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [3:0]     SEC_INIT = 4'(TURN_SECONDS);

    state_t          state, state_next;
    logic [8:0][1:0] board;
    logic [3:0]      place_idx;
    logic [3:0]      auto_idx;
    logic [PW-1:0]   prescaler;

    // [0],[1] form the synchroniser, [2] holds the previous synced level.
    logic [2:0] x_sync, o_sync, ng_sync;
    logic       req_x, req_o, req_ng;

    logic       mine_req, other_req, cell_free;
    logic       accept, reject, tick, timeout;
    cell_t      cell_code;
    logic       line_found;
    logic [2:0] line_id;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            x_sync  <= '0;
            o_sync  <= '0;
            ng_sync <= '0;
        end else begin
            x_sync  <= {x_sync[1:0], playX};
            o_sync  <= {o_sync[1:0], playO};
            ng_sync <= {ng_sync[1:0], new_game};
        end
    end

    assign req_x  = x_sync[1]  & ~x_sync[2];
    assign req_o  = o_sync[1]  & ~o_sync[2];
    assign req_ng = ng_sync[1] & ~ng_sync[2];

    // A request from the player not on turn is only an error when the player
    // on turn did not also request in the same cycle.
    assign mine_req  = turn ? req_o : req_x;
    assign other_req = turn ? req_x : req_o;
    assign cell_free = (position <= 4'd8) && (board[position] == EMPTY);
    assign accept    = (state == ST_TURN) && mine_req && cell_free;
    assign reject    = (mine_req && !cell_free) || (!mine_req && other_req);
    assign tick      = (prescaler == PRE_MAX);
    // An accepted player move in the tick cycle discards the timeout.
    assign timeout   = (state == ST_TURN) && !accept && tick && (seconds_left == 4'd1);
    assign cell_code = mark_of(turn);

    always_comb begin
        auto_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (board[i] == EMPTY) auto_idx = 4'(i);
        end
    end

    win_line_detector u_detect (
        .board   (board),
        .player  (cell_code),
        .found   (line_found),
        .line_id (line_id)
    );

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) state <= ST_TURN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_TURN:  if (accept || timeout) state_next = ST_PLACE;
            ST_PLACE: state_next = ST_CHECK;
            ST_CHECK: begin
                if (line_found)               state_next = turn ? ST_WIN_O : ST_WIN_X;
                else if (move_count == 4'd9)  state_next = ST_DRAW;
                else                          state_next = ST_TURN;
            end
            ST_WIN_X, ST_WIN_O, ST_DRAW: if (req_ng) state_next = ST_TURN;
            default:  state_next = ST_TURN;
        endcase
    end

    always_comb begin
        winner    = W_NONE;
        game_over = 1'b0;
        case (state)
            ST_WIN_X: begin winner = W_X;    game_over = 1'b1; end
            ST_WIN_O: begin winner = W_O;    game_over = 1'b1; end
            ST_DRAW:  begin winner = W_DRAW; game_over = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            board        <= '0;
            turn         <= 1'b0;
            win_line     <= 3'd0;
            seconds_left <= SEC_INIT;
            move_count   <= 4'd0;
            illegal_move <= 1'b0;
            prescaler    <= '0;
            place_idx    <= 4'd0;
        end else begin
            illegal_move <= 1'b0;
            case (state)
                ST_TURN: begin
                    if (accept) begin
                        place_idx <= position;
                    end else begin
                        illegal_move <= reject;
                        prescaler    <= tick ? '0 : prescaler + 1'b1;
                        if (tick) begin
                            seconds_left <= seconds_left - 1'b1;
                            if (seconds_left == 4'd1) place_idx <= auto_idx;
                        end
                    end
                end
                ST_PLACE: begin
                    board[place_idx] <= cell_code;
                    move_count       <= move_count + 1'b1;
                end
                ST_CHECK: begin
                    if (line_found) begin
                        win_line <= line_id;
                    end else if (move_count != 4'd9) begin
                        turn         <= ~turn;
                        seconds_left <= SEC_INIT;
                        prescaler    <= '0;
                    end
                end
                default: begin
                    // Game over: everything frozen until a restart request.
                    if (req_ng) begin
                        board        <= '0;
                        turn         <= 1'b0;
                        win_line     <= 3'd0;
                        move_count   <= 4'd0;
                        seconds_left <= SEC_INIT;
                        prescaler    <= '0;
                    end
                end
            endcase
        end
    end

    assign board_cells = board;

endmodule

// File: tb/tb_tictactoe_game_fsm.sv
module tb_tictactoe_game_fsm;

    localparam int CLK_HZ = 10;
    localparam int TS     = 3;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  position = 4'd0;
    logic        playX = 1'b0, playO = 1'b0, new_game = 1'b0;
    logic [17:0] board_cells;
    logic        turn, game_over, illegal_move;
    logic [1:0]  winner;
    logic [2:0]  win_line;
    logic [3:0]  seconds_left, move_count;

    tictactoe_game_fsm #(.CLK_HZ(CLK_HZ), .TURN_SECONDS(TS)) dut (
        .Clk(Clk), .rst(rst), .position(position), .playX(playX), .playO(playO),
        .new_game(new_game), .board_cells(board_cells), .turn(turn), .winner(winner),
        .game_over(game_over), .win_line(win_line), .seconds_left(seconds_left),
        .move_count(move_count), .illegal_move(illegal_move)
    );

    always #5 Clk = ~Clk;

    int total = 0, bad = 0, dut_ill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_TURN = 0, PH_PLACE = 1, PH_CHECK = 2, PH_OVER = 3;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int m_cells [9];
    int m_turn, m_winner, m_line, m_sec, m_moves, m_presc, m_phase, m_pidx;
    bit m_ill;
    bit [2:0] sx, so, sn;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_turn = 0; m_winner = 0; m_line = 0; m_sec = TS; m_moves = 0;
        m_presc = 0; m_phase = PH_TURN; m_pidx = 0; m_ill = 0;
        sx = 0; so = 0; sn = 0;
    endtask

    task automatic model_step();
        bit rx, ro, rn, mine, other, free;
        int p, pl, id;
        if (rst) begin
            model_reset();
            return;
        end
        rx = sx[1] & ~sx[2];
        ro = so[1] & ~so[2];
        rn = sn[1] & ~sn[2];
        sx = {sx[1:0], playX};
        so = {so[1:0], playO};
        sn = {sn[1:0], new_game};
        m_ill = 0;
        case (m_phase)
            PH_TURN: begin
                mine  = m_turn ? ro : rx;
                other = m_turn ? rx : ro;
                p     = int'(position);
                free  = (p <= 8) && (m_cells[p] == 0);
                if (mine && free) begin
                    m_pidx  = p;
                    m_phase = PH_PLACE;
                end else begin
                    m_ill = mine || other;
                    if (m_presc == CLK_HZ - 1) begin
                        m_presc = 0;
                        if (m_sec == 1) begin
                            m_sec = 0;
                            m_pidx = -1;
                            for (int i = 0; i < 9; i++)
                                if (m_pidx < 0 && m_cells[i] == 0) m_pidx = i;
                            m_phase = PH_PLACE;
                        end else begin
                            m_sec--;
                        end
                    end else begin
                        m_presc++;
                    end
                end
            end
            PH_PLACE: begin
                m_cells[m_pidx] = m_turn + 1;
                m_moves++;
                m_phase = PH_CHECK;
            end
            PH_CHECK: begin
                pl = m_turn + 1;
                id = -1;
                for (int l = 0; l < 8; l++)
                    if (id < 0 && m_cells[lines[l][0]] == pl && m_cells[lines[l][1]] == pl
                        && m_cells[lines[l][2]] == pl) id = l;
                if (id >= 0) begin
                    m_winner = pl; m_line = id; m_phase = PH_OVER;
                end else if (m_moves == 9) begin
                    m_winner = 3; m_phase = PH_OVER;
                end else begin
                    m_turn ^= 1; m_sec = TS; m_presc = 0; m_phase = PH_TURN;
                end
            end
            default: begin
                if (rn) begin
                    for (int i = 0; i < 9; i++) m_cells[i] = 0;
                    m_moves = 0; m_winner = 0; m_line = 0; m_turn = 0;
                    m_sec = TS; m_presc = 0; m_phase = PH_TURN;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or posedge rst);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [17:0] eb;
        forever begin
            @(negedge Clk);
            eb = '0;
            for (int i = 0; i < 9; i++) eb = eb | (18'(m_cells[i]) << (2 * i));
            check("board", board_cells, eb);
            check("turn", turn, m_turn);
            check("winner", winner, m_winner);
            check("game_over", game_over, m_winner != 0);
            check("win_line", win_line, m_line);
            check("seconds_left", seconds_left, m_sec);
            check("move_count", move_count, m_moves);
            check("illegal_move", illegal_move, m_ill);
            if (illegal_move === 1'b1) dut_ill++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic move(input bit is_o, input int pos);
        position = 4'(pos);
        if (is_o) playO = 1'b1; else playX = 1'b1;
        cyc(3);
        playX = 1'b0; playO = 1'b0;
        cyc(4);
    endtask

    task automatic ng();
        new_game = 1'b1;
        cyc(3);
        new_game = 1'b0;
        cyc(4);
    endtask

    initial begin
        int c0, n, r;
        rst = 1'b1;
        cyc(3);
        check("rst_board", board_cells, 18'h0);
        check("rst_seconds", seconds_left, 4'd3);
        check("rst_winner", winner, 2'b00);
        rst = 1'b0;
        cyc(2);

        // X wins on the top row
        move(0, 0); move(1, 3); move(0, 1); move(1, 4); move(0, 2);
        check("t1_winner", winner, 2'b01);
        check("t1_win_line", win_line, 3'd0);
        check("t1_game_over", game_over, 1'b1);
        check("t1_board", board_cells, 18'h00295);
        check("t1_moves", move_count, 4'd5);
        ng();
        check("t1_ng_board", board_cells, 18'h0);
        check("t1_ng_winner", winner, 2'b00);

        // timeout auto-move for X at the lowest empty cell
        move(0, 0); move(1, 1);
        n = 0;
        while (turn !== 1'b1 && n < 80) begin @(negedge Clk); n++; end
        check("t4_wait_auto", n < 80, 1);
        check("t4_cell2", board_cells[5:4], 2'b01);
        check("t4_seconds", seconds_left, 4'd3);
        check("t4_moves", move_count, 4'd3);

        // illegal requests on O's turn
        c0 = dut_ill; move(0, 5);  check("t2_wrong_turn", dut_ill - c0, 1);
        c0 = dut_ill; move(1, 0);  check("t2_occupied", dut_ill - c0, 1);
        c0 = dut_ill; move(1, 12); check("t2_bad_pos", dut_ill - c0, 1);
        check("t2_board", board_cells, 18'h00019);

        // reset while the move is in flight
        position = 4'd6; playO = 1'b1;
        cyc(3);
        rst = 1'b1; playO = 1'b0;
        cyc(2);
        check("t6_board", board_cells, 18'h0);
        check("t6_moves", move_count, 4'd0);
        check("t6_turn", turn, 1'b0);
        rst = 1'b0;
        cyc(2);

        // draw
        move(0, 0); move(1, 1); move(0, 2); move(1, 4); move(0, 3);
        move(1, 5); move(0, 7); move(1, 6); move(0, 8);
        check("t3_winner", winner, 2'b11);
        check("t3_moves", move_count, 4'd9);
        check("t3_game_over", game_over, 1'b1);
        check("t3_board", board_cells, 18'h16A59);
        c0 = dut_ill; move(0, 4);
        check("t3_frozen_ill", dut_ill - c0, 0);
        check("t3_frozen_winner", winner, 2'b11);
        ng();
        check("t6_ng_board", board_cells, 18'h0);
        check("t6_ng_turn", turn, 1'b0);

        // simultaneous X and O edges on X's turn
        c0 = dut_ill;
        position = 4'd4; playX = 1'b1; playO = 1'b1;
        cyc(3);
        playX = 1'b0; playO = 1'b0;
        cyc(4);
        check("t5_both_board", board_cells, 18'h00100);
        check("t5_both_ill", dut_ill - c0, 0);
        // O request lands in the cycle of the final timeout tick
        n = 0;
        while (!(m_phase == PH_TURN && m_sec == 1 && m_presc == CLK_HZ - 3) && n < 100) begin
            cyc(1); n++;
        end
        check("t5_align", n < 100, 1);
        move(1, 8);
        check("t5_tick_board", board_cells, 18'h20100);
        check("t5_tick_turn", turn, 1'b0);
        ng();
        check("t6_mid_ng_board", board_cells, 18'h20100);
        check("t6_mid_ng_moves", move_count, 4'd2);

        // random play
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            n = $urandom_range(0, 15);
            if (r < 30)      move(0, n);
            else if (r < 60) move(1, n);
            else if (r < 68) begin
                position = 4'(n); playX = 1'b1; playO = 1'b1;
                cyc(3);
                playX = 1'b0; playO = 1'b0;
                cyc(3);
            end
            else if (r < 78) ng();
            else if (r < 81) begin rst = 1'b1; cyc(2); rst = 1'b0; cyc(1); end
            else if (r < 89) cyc($urandom_range(5, 35));
            else begin
                position = 4'(n);
                playX = 1'($urandom); playO = 1'($urandom); new_game = 1'($urandom);
                cyc(1);
            end
        end
        playX = 1'b0; playO = 1'b0; new_game = 1'b0;
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
